// File: rtl/mux_rr_scheduler.sv
// -----------------------------------------------------------------------------
// mux_rr_scheduler
//
// Round-robin scheduler sharing one 8:1 bit mux between 8 producer lanes and a
// single serial consumer. The winning lane index is registered onto the mux
// select. The muxed bit is presented with a valid/ready handshake. A grant is
// held for a burst until the lane drops its request or MAX_HOLD beats have been
// accepted. Every release returns to idle for one bubble cycle before the next
// arbitration.
//
// Parameters:
//   MAX_HOLD  maximum accepted beats per grant (1..15)
//   CNT_W     beat counter width, 2**CNT_W > MAX_HOLD
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous reset, active-high, highest priority
//   req[7:0]   in   per-lane request
//   in[7:0]    in   per-lane data bit
//   ready      in   consumer accepts the beat this cycle
//   prio_mask  in   (MUX_SCHED_PRIO_EN only) lanes in the priority class
//   gnt[7:0]   out  registered one-hot grant, zero when idle
//   sel[2:0]   out  registered index of the granted lane
//   valid      out  out carries a beat from the granted lane
//   out        out  in[sel] gated by valid
//
// Optional feature macro: MUX_SCHED_PRIO_EN
//   When defined, the idle search runs over (req & prio_mask) whenever that is
//   nonzero, otherwise over req. The rotation pointer is shared by both
//   classes, and an active grant is never preempted.
// -----------------------------------------------------------------------------
module mux_rr_scheduler #(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    input  logic [7:0] in,
    input  logic       ready,
`ifdef MUX_SCHED_PRIO_EN
    input  logic [7:0] prio_mask,
`endif
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       valid,
    output logic       out
);

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_GRANT = 1'b1;

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_HOLD - 1);

    logic             state_q, state_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [7:0] cand;
    logic       found;
    logic [2:0] pick;
    logic [2:0] idx;
    logic       xfer;
    logic       rel;

    // Candidate pool for the idle search.
    always_comb begin
        cand = req;
`ifdef MUX_SCHED_PRIO_EN
        if ((req & prio_mask) != 8'h00) begin
            cand = req & prio_mask;
        end
`endif
    end

    // First set candidate at or after ptr, wrapping 7 -> 0.
    always_comb begin
        found = 1'b0;
        pick  = 3'd0;
        idx   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            idx = ptr_q + 3'(k);
            if (!found && cand[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
    end

    // Handshake outputs. valid follows the granted lane's request directly so a
    // dropped request suppresses the beat in the same cycle.
    always_comb begin
        valid = (state_q == ST_GRANT) && req[sel_q];
        out   = valid && in[sel_q];
        xfer  = valid && ready;
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    state_d = ST_GRANT;
                    sel_d   = pick;
                    gnt_d   = 8'h01 << pick;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (!req[sel_q]) begin
                    rel = 1'b1;
                end else if (xfer) begin
                    if (cnt_q == LAST_BEAT) begin
                        rel = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                // A stall (valid && !ready) falls through with everything held.
                if (rel) begin
                    state_d = ST_IDLE;
                    gnt_d   = 8'h00;
                    ptr_d   = sel_q + 3'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= 8'h00;
            sel_q   <= 3'd0;
            ptr_q   <= 3'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    assign gnt = gnt_q;
    assign sel = sel_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert ($onehot0(gnt_q));
            assert ((gnt_q != 8'h00) == (state_q == ST_GRANT));
            assert ((gnt_q == 8'h00) || gnt_q[sel_q]);
        end
    end
`endif

endmodule

// File: doc/mux_rr_scheduler.md
Name: mux_rr_scheduler

Overview:
Round-robin scheduler that shares one 8:1 bit mux between 8 requesters. It registers the winning requester's index onto the mux select and gates the muxed bit out with a valid/ready handshake. A grant is held for a burst until the requester drops its request or MAX_HOLD beats transfer. The block sits between the 8 producer lanes and a single serial consumer.

Parameters:
MAX_HOLD, 4, maximum accepted beats per grant (legal range 1..15).
CNT_W, 4, width of the beat counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous reset, active-high.
req  input  8  per-lane request; req[i]=1 means lane i has a bit to send.
in  input  8  per-lane data bit; in[i] belongs to lane i.
ready  input  1  consumer accepts the beat this cycle.
gnt  output  8  one-hot registered grant; all zero when idle.
sel  output  3  registered index of the granted lane (mux select).
valid  output  1  out carries a beat from the granted lane.
out  output  1  muxed data bit, in[sel] gated by valid.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, gnt=8'h00, sel=3'd0, ptr=3'd0, beat count=0. Combinationally this gives valid=0 and out=0. rst has priority over all other events.
- Reset mid-grant: the grant drops at that edge. No beat is counted for that cycle. The next arbitration starts from ptr=0.
- State IDLE:
  - If req is zero, stay in IDLE.
  - Otherwise pick the first i with req[i]=1, searching ptr, ptr+1, ... mod 8 (wraps 7->0).
  - At the next edge: sel=i, gnt=1<<i, count=0, state=GRANT.
  - Latency: req asserted before edge t gives gnt and sel visible after edge t, i.e. 1 cycle.
- State GRANT:
  - valid = req[sel] (combinational). out = valid ? in[sel] : 0.
  - A beat transfers when valid and ready are both 1. Each transfer increments count.
  - Release occurs at the edge where either:
    - req[sel]=0 (the requester dropped; no transfer that cycle), or
    - a transfer occurs with count == MAX_HOLD-1 (the final beat is accepted).
  - On release: gnt=0, ptr=sel+1 mod 8, state=IDLE. This always inserts one idle bubble cycle between grants.
  - valid=1 with ready=0: hold. sel, gnt and count are unchanged, and the grant never times out on stall.
- Other inputs during GRANT: changes on non-granted req bits and on in[] bits are ignored. out follows in[sel] combinationally, so the producer must hold in[sel] stable while valid && !ready.
- Single persistent requester: it is regranted after each bubble. A MAX_HOLD-beat burst costs MAX_HOLD+1 cycles with ready=1.
- Invariants:
  - gnt is one-hot or zero.
  - gnt != 0 if and only if state == GRANT.
  - When gnt != 0, gnt[sel]=1.

Optional Feature:
MUX_SCHED_PRIO_EN
- Defined: adds input prio_mask[7:0].
  - In IDLE, if (req & prio_mask) is nonzero, the round-robin search runs over (req & prio_mask) only. Otherwise it runs over req.
  - ptr is shared between both classes.
  - An active grant is never preempted.
- Undefined: the prio_mask port is absent and the scheduler is pure round-robin as above.

Test Plan:
- Reset then req=8'h00 for 5 cycles -> gnt=0, sel=0, valid=0, out=0 throughout.
- req=8'h81, ptr=0, ready=1, held -> grant lane 0 for 4 beats, bubble, then lane 7 for 4 beats, bubble, then lane 0 again (wrap 7->0 verified).
- Lane 3 only, req[3]=1, in[3] toggling, ready pattern 1,0,0,1,1,1 -> valid stays 1. Exactly 4 transfers are counted; sel=3 and gnt=8'h08 are held through the stalls; release follows the 4th accepted beat.
- Lane 5 granted, req[5] dropped after 2 beats -> valid=0 that cycle. gnt=0 next cycle, ptr=6. With req=8'h21, lane 0 is granted next.
- rst pulsed while lane 2 granted mid-burst -> gnt=0, sel=0, valid=0 after the edge. Next grant comes from a search starting at 0.
- With MUX_SCHED_PRIO_EN, req=8'hFF, prio_mask=8'h10 -> lane 4 is granted repeatedly. With prio_mask=0 -> rotation 5,6,7,0,...
